fpu_issue_controller: RTL and testbench

- Requester side of the Fixed-Point Unit interface. It sits between the execute stage and the FPU.
- Accepts one fixed-point request at a time with a valid/ready handshake, holds the operation and operands stable on the FPU inputs, and waits for FPU ready.
- Returns the result (or a timeout) through a valid/ready response channel and raises a pipeline stall while busy.

---
 rtl/fpu_issue_controller_pkg.sv | 20 ++
 rtl/fpu_issue_controller_if.sv | 38 +++
 rtl/fpu_wait_timer.sv | 23 ++
 rtl/fpu_issue_controller.sv | 95 +++++++++
 tb/tb_fpu_issue_controller.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fpu_issue_controller_pkg.sv
// Shared FPU opcodes, issue-controller state encoding and small helpers.
package fpu_issue_controller_pkg;

  localparam logic [1:0] FPU_ADD  = 2'd0;
  localparam logic [1:0] FPU_SUB  = 2'd1;
  localparam logic [1:0] FPU_MUL  = 2'd2;
  localparam logic [1:0] FPU_SQRT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fic_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fpu_issue_controller_if.sv
// Request, FPU and response channels of the FPU issue controller.
interface fpu_issue_controller_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_operation;
  logic [WIDTH-1:0] req_operand_1;
  logic [WIDTH-1:0] req_operand_2;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic             stall;
  logic [7:0]       timeout_count;

  modport master (
    output req_valid, req_operation, req_operand_1, req_operand_2, req_tag,
           fpu_result, fpu_ready, rsp_ready,
    input  req_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
           rsp_valid, rsp_result, rsp_tag, rsp_timeout, stall, timeout_count
  );

  modport slave (
    input  req_valid, req_operation, req_operand_1, req_operand_2, req_tag,
           fpu_result, fpu_ready, rsp_ready,
    output req_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
           rsp_valid, rsp_result, rsp_tag, rsp_timeout, stall, timeout_count
  );
endinterface

// File: rtl/fpu_wait_timer.sv
// Down-counter bounding the FPU wait; expire rises after TIMEOUT_CYCLES-1 enabled cycles.
module fpu_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= LOAD;
    else if (clr)              cnt <= LOAD;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/fpu_issue_controller.sv
// Requester side of the fixed-point unit: one op in flight, held operands, timeout abort.
module fpu_issue_controller
  import fpu_issue_controller_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int FBITS          = 10,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  fpu_issue_controller_if.slave  bus
);
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (FBITS >= WIDTH) begin : g_bad_fbits
    $error("FBITS must be smaller than WIDTH");
  end

  fic_state_e       state, state_nxt;
  logic [1:0]       hold_op;
  logic [WIDTH-1:0] hold_a, hold_b;
  logic [TAG_W-1:0] hold_tag;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_timeout_q;
  logic [7:0]       to_cnt_q;
  logic             expire;

  fpu_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == ISSUE),
    .en     (state == WAIT),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ISSUE never looks at fpu_ready, so a ready left high by the last op is masked.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.req_valid)                state_nxt = ISSUE;
      ISSUE:                                   state_nxt = WAIT;
      WAIT:  if (bus.fpu_ready || expire)      state_nxt = RESP;
      RESP:  if (bus.rsp_ready)                state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_op       <= '0;
      hold_a        <= '0;
      hold_b        <= '0;
      hold_tag      <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        hold_op  <= bus.req_operation;
        hold_a   <= bus.req_operand_1;
        hold_b   <= bus.req_operand_2;
        hold_tag <= bus.req_tag;
      end
      // Ready wins over a coinciding expiry.
      if (state == WAIT) begin
        if (bus.fpu_ready) begin
          rsp_result_q  <= bus.fpu_result;
          rsp_timeout_q <= 1'b0;
        end else if (expire) begin
          rsp_result_q  <= '0;
          rsp_timeout_q <= 1'b1;
          to_cnt_q      <= sat_inc8(to_cnt_q);
        end
      end
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.stall         = bus.req_valid && (state != IDLE);
  assign bus.fpu_operation = hold_op;
  assign bus.fpu_operand_1 = hold_a;
  assign bus.fpu_operand_2 = hold_b;
  assign bus.rsp_valid     = (state == RESP);
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_tag       = hold_tag;
  assign bus.rsp_timeout   = rsp_timeout_q;
  assign bus.timeout_count = to_cnt_q;
endmodule

// File: tb/tb_fpu_issue_controller.sv
// Transaction-level bench: each request predicts result, latency and timeout count.
module tb_fpu_issue_controller;
  import fpu_issue_controller_pkg::*;

  localparam int WIDTH = 32;
  localparam int FBITS = 10;
  localparam int TO    = 64;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fpu_rdy = 1'b0;
  always #5 clk = ~clk;

  fpu_issue_controller_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  fpu_issue_controller #(
    .WIDTH(WIDTH), .FBITS(FBITS), .TIMEOUT_CYCLES(TO), .TAG_W(TAG_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural FPU: combinational arithmetic on whatever the controller presents.
  function automatic logic [WIDTH-1:0] fpu_calc(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [63:0] p;
    case (op)
      FPU_ADD: return a + b;
      FPU_SUB: return a - b;
      FPU_MUL: begin p = (64'(a) * 64'(b)) >> FBITS; return p[WIDTH-1:0]; end
      default: return a >> 1;
    endcase
  endfunction

  assign bus.fpu_ready  = fpu_rdy;
  assign bus.fpu_result = fpu_calc(bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2);

  int n_cmp = 0;
  int n_err = 0;
  int to_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // d: number of WAIT cycles before the FPU raises ready (>= TO means never in time).
  // hold: cycles the consumer delays rsp_ready. stale: ready already high in ISSUE.
  // press: keep a second request pending while busy.
  task automatic run_txn(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tg,
                         input int d, input int hold, input bit stale, input bit press);
    int lat, j;
    bit to;
    logic [WIDTH-1:0] er;
    to  = (d > TO - 1);
    er  = to ? '0 : fpu_calc(op, a, b);
    lat = to ? TO + 1 : d + 2;
    if (to && to_cnt < 255) to_cnt++;

    bus.req_valid     = 1'b1;
    bus.req_operation = op;
    bus.req_operand_1 = a;
    bus.req_operand_2 = b;
    bus.req_tag       = tg;
    fpu_rdy           = stale;
    #1;
    chk("req_ready_idle", bus.req_ready, 1);
    chk("stall_idle", bus.stall, 0);
    @(posedge clk); @(negedge clk);
    bus.req_valid = press;
    fpu_rdy       = stale;
    #1;
    chk("fpu_op", bus.fpu_operation, op);
    chk("fpu_a", bus.fpu_operand_1, a);
    chk("fpu_b", bus.fpu_operand_2, b);
    if (press) chk("stall_issue", bus.stall, 1);
    j = 0;
    while (!bus.rsp_valid && j < TO + 20) begin
      @(posedge clk); @(negedge clk);
      j++;
      if (!bus.rsp_valid) begin
        fpu_rdy = (j > d);
        if (press) begin #1; chk("stall_busy", bus.stall, 1); end
      end
    end
    chk("rsp_latency", j, lat);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_result", bus.rsp_result, er);
    chk("rsp_tag", bus.rsp_tag, tg);
    chk("rsp_timeout", bus.rsp_timeout, to);
    chk("timeout_count", bus.timeout_count, to_cnt);
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      #1;
      chk("rsp_hold_valid", bus.rsp_valid, 1);
      chk("rsp_hold_result", bus.rsp_result, er);
      chk("req_ready_resp", bus.req_ready, 0);
      if (press) chk("stall_resp", bus.stall, 1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("rsp_done", bus.rsp_valid, 0);
    chk("req_ready_back", bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_operation = '0;
    bus.req_operand_1 = '0;
    bus.req_operand_2 = '0;
    bus.req_tag       = '0;
    bus.rsp_ready     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_fpu_op", bus.fpu_operation, 0);
    chk("rst_fpu_a", bus.fpu_operand_1, 0);
    chk("rst_fpu_b", bus.fpu_operand_2, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    chk("rst_timeout_count", bus.timeout_count, 0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(FPU_ADD,  32'h600, 32'h900, 5'd7, 0, 0, 1'b0, 1'b0);
    run_txn(FPU_MUL,  32'h600, 32'h900, 5'd3, 5, 4, 1'b0, 1'b1);
    run_txn(FPU_SUB,  32'hA00, 32'h400, 5'd9, 0, 0, 1'b1, 1'b0);
    run_txn(FPU_SQRT, 32'h1234, 32'h0, 5'd1, 1000, 1, 1'b0, 1'b0);
    run_txn(FPU_ADD,  32'h11, 32'h22, 5'd2, TO - 1, 0, 1'b0, 1'b0);
    run_txn(FPU_MUL,  32'h400, 32'h800, 5'd4, TO - 2, 1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? TO - 2 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 9));
      run_txn(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)),
              d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 299; i++)
      run_txn(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(i), TO, 0, 1'b0, 1'b0);
    chk("timeout_sat", bus.timeout_count, 255);

    // Abort mid-WAIT with an asynchronous reset.
    bus.req_valid = 1'b0;
    fpu_rdy = 1'b0;
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_operation = FPU_SQRT;
    bus.req_operand_1 = 32'hABCD;
    bus.req_operand_2 = 32'h5;
    bus.req_tag       = 5'd12;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req_ready", bus.req_ready, 1);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_fpu_a", bus.fpu_operand_1, 0);
    chk("rst_mid_fpu_op", bus.fpu_operation, 0);
    chk("rst_mid_timeout_count", bus.timeout_count, 0);
    to_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    fpu_rdy = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 0);
    end
    run_txn(FPU_ADD, 32'h100, 32'h200, 5'd30, 2, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
